// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e : controller FSM states
//   lsu_fault_e : fault codes reported on fault_code
//   OP_*        : opcode[6:4] values that select a memory op
//   F3_*        : funct3 access size / sign encodings
//   f3_legal()  : funct3 legality for a load or a store
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_MISAL   = 2'b01,
        FLT_TIMEOUT = 2'b10,
        FLT_ILLEGAL = 2'b11
    } lsu_fault_e;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b010;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know B/H/W; loads additionally accept the unsigned forms.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for one access.
//   is_store   in  : access is a store (affects funct3 legality only)
//   funct3     in  : access size / sign
//   addr_lo    in  : byte offset within the word
//   wdata      in  : store data, low bytes significant
//   mem_rdata  in  : raw word from memory
//   be         out : byte-lane enables
//   wdata_rep  out : store data replicated across all lanes
//   rdata_ext  out : load data shifted down and sign/zero-extended
//   misaligned out : H/HU on an odd address, or W not on a word boundary
//   illegal    out : funct3 not valid for this kind of access
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = mem_rdata >> {addr_lo, 3'b000};
        illegal    = ~f3_legal(is_store, funct3);
        misaligned = 1'b0;
        be         = 4'b0000;
        rdata_ext  = shifted;

        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                be        = 4'b0001 << addr_lo;
                rdata_ext = {24'h0, shifted[7:0]};
            end
            F3_H: begin
                be         = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                be         = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                rdata_ext  = {16'h0, shifted[15:0]};
            end
            F3_W: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
                rdata_ext  = shifted;
            end
            default: begin
                be        = 4'b0000;
                rdata_ext = shifted;
            end
        endcase

        // Only the size bits matter for replication; the sign bit is a load concept.
        case (funct3[1:0])
            2'b00:   wdata_rep = {4{wdata[7:0]}};
            2'b01:   wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencing controller between execute and data memory.
//   TIMEOUT              : ISSUE cycles to wait for mem_ready before a timeout fault (1..255)
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   lsu_valid/op654/funct3/addr/wdata : core request, held while lsu_stall=1
//   lsu_stall            : core must hold PC and request inputs
//   lsu_done             : one-cycle completion pulse (success or fault)
//   lsu_rdata            : extended load data, holds last value between loads
//   lsu_fault/fault_code : fault qualifier and code, valid with lsu_done
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : word-addressed memory request
//   mem_ready/mem_rdata  : memory completion and read word
//   state_dbg            : current FSM state
//
// Handshake: the core presents lsu_valid with a stable request; the request is
// taken in the IDLE cycle it appears and the core keeps it stable while
// lsu_stall=1. Toward memory, mem_req stays high with stable mem_* until the
// first cycle mem_ready=1, which completes the access; mem_ready without
// mem_req is ignored.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic [2:0]  op654,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_fault,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output lsu_state_e  state_dbg
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    lsu_state_e  state;
    lsu_fault_e  code_q;
    logic        req_store;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  cnt;

    logic        in_idle;
    logic        in_issue;
    logic        op_is_mem;
    logic        accept;

    logic        al_store;
    logic [2:0]  al_f3;
    logic [1:0]  al_addr_lo;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_wdata_rep;
    logic [31:0] al_rdata_ext;
    logic        al_misal;
    logic        al_illegal;

    assign in_idle   = (state == ST_IDLE);
    assign in_issue  = (state == ST_ISSUE);
    assign op_is_mem = (op654 == OP_LOAD) || (op654 == OP_STORE);
    assign accept    = in_idle && lsu_valid && op_is_mem;

    // In IDLE the aligner judges the live request (legality/alignment);
    // afterwards it works from the latched copy so mem_* stay stable.
    assign al_store   = in_idle ? (op654 == OP_STORE) : req_store;
    assign al_f3      = in_idle ? funct3 : req_f3;
    assign al_addr_lo = in_idle ? addr[1:0] : req_addr[1:0];
    assign al_wdata   = in_idle ? wdata : req_wdata;

    lsu_lane_align u_align (
        .is_store   (al_store),
        .funct3     (al_f3),
        .addr_lo    (al_addr_lo),
        .wdata      (al_wdata),
        .mem_rdata  (mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata_rep),
        .rdata_ext  (al_rdata_ext),
        .misaligned (al_misal),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            code_q    <= FLT_NONE;
            req_store <= 1'b0;
            req_f3    <= 3'b000;
            req_addr  <= 32'h0;
            req_wdata <= 32'h0;
            cnt       <= 8'h0;
            lsu_done  <= 1'b0;
            lsu_fault <= 1'b0;
            lsu_rdata <= 32'h0;
            mem_req   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lsu_done  <= 1'b0;
                    lsu_fault <= 1'b0;
                    code_q    <= FLT_NONE;
                    if (accept) begin
                        req_store <= (op654 == OP_STORE);
                        req_f3    <= funct3;
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        if (al_illegal) begin
                            state     <= ST_DONE;
                            lsu_done  <= 1'b1;
                            lsu_fault <= 1'b1;
                            code_q    <= FLT_ILLEGAL;
                        end else if (al_misal) begin
                            state     <= ST_DONE;
                            lsu_done  <= 1'b1;
                            lsu_fault <= 1'b1;
                            code_q    <= FLT_MISAL;
                        end else begin
                            state   <= ST_ISSUE;
                            cnt     <= 8'h0;
                            mem_req <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_req && mem_ready) begin
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        lsu_done <= 1'b1;
                        if (!req_store) begin
                            lsu_rdata <= al_rdata_ext;
                        end
                    end else if (cnt == TO_LIMIT) begin
                        // mem_req was already dropped in the previous cycle.
                        state     <= ST_DONE;
                        lsu_done  <= 1'b1;
                        lsu_fault <= 1'b1;
                        code_q    <= FLT_TIMEOUT;
                    end else begin
                        cnt <= cnt + 8'h1;
                        if (cnt == TO_LAST) begin
                            mem_req <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    lsu_done  <= 1'b0;
                    lsu_fault <= 1'b0;
                    code_q    <= FLT_NONE;
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the combinational accept term so stall falls at once.
    assign lsu_stall  = ~reset & (accept | in_issue);
    assign fault_code = code_q;
    assign state_dbg  = state;

    assign mem_we    = in_issue & req_store;
    assign mem_addr  = in_issue ? {req_addr[31:2], 2'b00} : 32'h0;
    assign mem_be    = in_issue ? al_be : 4'b0000;
    assign mem_wdata = in_issue ? al_wdata_rep : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid;
    logic [2:0]  op654;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_fault;
    logic [1:0]  fault_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    lsu_state_e  state_dbg;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_valid  (lsu_valid),
        .op654      (op654),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .lsu_stall  (lsu_stall),
        .lsu_done   (lsu_done),
        .lsu_rdata  (lsu_rdata),
        .lsu_fault  (lsu_fault),
        .fault_code (fault_code),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    typedef struct {
        int          done_cyc;
        logic [1:0]  code;
        int          req_cnt;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic        we;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          done_cyc;
        int          stall_cnt;
        int          req_cnt;
        logic [1:0]  code;
        logic        fault;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        stable;
    } obs_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          waits;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    // ---------------- reference model ----------------
    // Works on byte counts and lane positions rather than encodings of be/shift.
    function automatic exp_t model(input logic [2:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input int waits,
                                   input logic [31:0] prev);
        exp_t e;
        int bytes;
        int off;
        bit legal;
        longint v;
        logic [31:0] w;
        bytes = 1 << (f3 % 4);
        off   = a % 4;
        if (op == OP_STORE) legal = (f3 <= 2);
        else                legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
        e.we     = (op == OP_STORE);
        e.maddr  = a - off;
        e.be     = 4'h0;
        e.mwdata = 32'h0;
        e.rdata  = prev;
        if (!legal) begin
            e.code = 2'd3; e.done_cyc = 1; e.req_cnt = 0;
        end else if ((a % bytes) != 0) begin
            e.code = 2'd1; e.done_cyc = 1; e.req_cnt = 0;
        end else if (waits >= TO) begin
            e.code = 2'd2; e.done_cyc = TO + 2; e.req_cnt = TO;
        end else begin
            e.code = 2'd0; e.done_cyc = 2 + waits; e.req_cnt = waits + 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + bytes) e.be[i] = 1'b1;
            w = wd >> (8 * (i % bytes));
            e.mwdata[8*i +: 8] = w[7:0];
        end
        if (op == OP_LOAD && e.code == 2'd0) begin
            v = 0;
            for (int k = 0; k < bytes; k++) v = v + (longint'((rd >> (8 * (off + k))) & 32'hFF) << (8 * k));
            if (f3 < 4 && bytes < 4 && v >= (longint'(1) << (8 * bytes - 1)))
                v = v - (longint'(1) << (8 * bytes));
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    // ---------------- driver ----------------
    // Enters and leaves 1 time unit after a rising edge; cycle 0 is the request cycle.
    task automatic run_txn(input logic [2:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits,
                           input bit drop, output obs_t o);
        logic prev_stall;
        o.done_cyc = -1; o.stall_cnt = 0; o.req_cnt = 0; o.code = 2'bxx; o.fault = 1'bx;
        o.rdata = 32'hx; o.we = 1'b0; o.maddr = 32'h0; o.be = 4'h0; o.mwdata = 32'h0; o.stable = 1'b1;
        prev_stall = 1'b1;
        for (int c = 0; c < TO + 8; c++) begin
            lsu_valid = (c == 0) || (!drop && prev_stall);
            op654 = op; funct3 = f3; addr = a; wdata = wd;
            mem_ready = (waits < TO) && (c == 1 + waits);
            mem_rdata = mem_ready ? rd : $urandom();
            @(negedge clk);
            if (lsu_stall) o.stall_cnt++;
            if (mem_req) begin
                if (o.req_cnt == 0) begin
                    o.we = mem_we; o.maddr = mem_addr; o.be = mem_be; o.mwdata = mem_wdata;
                end else if (mem_we !== o.we || mem_addr !== o.maddr || mem_be !== o.be || mem_wdata !== o.mwdata) begin
                    o.stable = 1'b0;
                end
                o.req_cnt++;
            end
            if (lsu_done && o.done_cyc < 0) begin
                o.done_cyc = c; o.code = fault_code; o.fault = lsu_fault; o.rdata = lsu_rdata;
            end
            prev_stall = lsu_stall;
            @(posedge clk); #1;
            if (o.done_cyc >= 0) break;
        end
        lsu_valid = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e);
        logic [31:0] er;
        chk({tag, ".done_cycle"}, o.done_cyc, e.done_cyc);
        chk({tag, ".fault_code"}, o.code, e.code);
        chk({tag, ".lsu_fault"}, o.fault, (e.code != 2'd0));
        chk({tag, ".stall_cycles"}, o.stall_cnt, e.done_cyc);
        chk({tag, ".mem_req_cycles"}, o.req_cnt, e.req_cnt);
        if (exp_q.size() > 0) er = exp_q.pop_front();
        else er = 32'hx;
        chk({tag, ".lsu_rdata"}, o.rdata, er);
        if (e.req_cnt > 0 && o.req_cnt > 0) begin
            chk({tag, ".mem_addr"}, o.maddr, e.maddr);
            chk({tag, ".mem_be"}, o.be, e.be);
            chk({tag, ".mem_we"}, o.we, e.we);
            chk({tag, ".mem_stable"}, o.stable, 1'b1);
            if (e.we) chk({tag, ".mem_wdata"}, o.mwdata, e.mwdata);
        end
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits,
                           input int dc, input logic [1:0] code, input int rq, input logic [3:0] be,
                           input logic [31:0] ma, input logic [31:0] mw, input logic [31:0] rdx);
        vec_t v;
        v.op = op; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.waits = waits;
        v.e.done_cyc = dc; v.e.code = code; v.e.req_cnt = rq; v.e.be = be;
        v.e.maddr = ma; v.e.we = (op == OP_STORE); v.e.mwdata = mw; v.e.rdata = rdx;
        vecs.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        obs_t o;
        exp_t e;
        logic [2:0] rop;
        logic [2:0] rf3;
        logic [31:0] ra, rwd, rrd;
        int rw;

        reset = 1'b1; lsu_valid = 1'b0; op654 = 3'b0; funct3 = 3'b0; addr = 32'h0;
        wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        last_rd = 32'h0;

        // op f3 addr wdata mem_rdata waits | done code reqs be mem_addr mem_wdata lsu_rdata
        add_vec(OP_LOAD,  F3_B,  32'h103, 32'h0,        32'h80FF1234, 0, 2, 2'd0, 1, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80);
        add_vec(OP_LOAD,  F3_HU, 32'h202, 32'h0,        32'hBEEF0000, 3, 5, 2'd0, 4, 4'hC, 32'h200, 32'h0,        32'h0000BEEF);
        add_vec(OP_STORE, F3_B,  32'h011, 32'h000000A5, 32'h0,        0, 2, 2'd0, 1, 4'h2, 32'h010, 32'hA5A5A5A5, 32'h0000BEEF);
        add_vec(OP_STORE, F3_W,  32'h012, 32'h11223344, 32'h0,        0, 1, 2'd1, 0, 4'h0, 32'h0,   32'h0,        32'h0000BEEF);
        add_vec(OP_LOAD,  3'b011,32'h040, 32'h0,        32'h0,        0, 1, 2'd3, 0, 4'h0, 32'h0,   32'h0,        32'h0000BEEF);
        add_vec(OP_STORE, 3'b100,32'h040, 32'h0,        32'h0,        0, 1, 2'd3, 0, 4'h0, 32'h0,   32'h0,        32'h0000BEEF);
        add_vec(OP_LOAD,  F3_W,  32'h020, 32'h0,        32'h55555555, 5, 6, 2'd2, 4, 4'hF, 32'h020, 32'h0,        32'h0000BEEF);
        add_vec(OP_LOAD,  F3_W,  32'h024, 32'h0,        32'h12345678, 3, 5, 2'd0, 4, 4'hF, 32'h024, 32'h0,        32'h12345678);
        add_vec(OP_LOAD,  F3_H,  32'h032, 32'h0,        32'h80010000, 1, 3, 2'd0, 2, 4'hC, 32'h030, 32'h0,        32'hFFFF8001);
        add_vec(OP_STORE, F3_H,  32'h006, 32'h1234ABCD, 32'h0,        2, 4, 2'd0, 3, 4'hC, 32'h004, 32'hABCDABCD, 32'hFFFF8001);
        add_vec(OP_LOAD,  F3_HU, 32'h001, 32'h0,        32'h0,        0, 1, 2'd1, 0, 4'h0, 32'h0,   32'h0,        32'hFFFF8001);
        add_vec(OP_LOAD,  F3_BU, 32'h002, 32'h0,        32'h00C30000, 0, 2, 2'd0, 1, 4'h4, 32'h000, 32'h0,        32'h000000C3);

        repeat (2) @(posedge clk);
        #1;
        chk("reset.lsu_stall", lsu_stall, 1'b0);
        chk("reset.lsu_done", lsu_done, 1'b0);
        chk("reset.lsu_rdata", lsu_rdata, 32'h0);
        chk("reset.fault_code", fault_code, 2'd0);
        chk("reset.mem_req", mem_req, 1'b0);
        chk("reset.mem_be", mem_be, 4'h0);
        chk("reset.state", state_dbg, ST_IDLE);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table vectors, back to back.
        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i].e.rdata);
            run_txn(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].waits, 1'b0, o);
            compare($sformatf("vec%0d", i), o, vecs[i].e);
            last_rd = vecs[i].e.rdata;
        end

        // Non-memory opcode: no stall, no traffic, no done.
        for (int c = 0; c < 3; c++) begin
            lsu_valid = 1'b1; op654 = 3'b011; funct3 = F3_W; addr = 32'h0;
            @(negedge clk);
            chk("ignored_op.stall", lsu_stall, 1'b0);
            chk("ignored_op.req_done", {mem_req, lsu_done}, 2'b00);
            @(posedge clk); #1;
        end
        lsu_valid = 1'b0;

        // lsu_valid dropped after the request cycle: the access still completes.
        e = model(OP_LOAD, F3_H, 32'h00000082, 32'h0, 32'h00007F00, 2, last_rd);
        exp_q.push_back(e.rdata);
        run_txn(OP_LOAD, F3_H, 32'h00000082, 32'h0, 32'h00007F00, 2, 1'b1, o);
        compare("drop_valid", o, e);
        last_rd = e.rdata;

        // Reset in the second ISSUE cycle.
        lsu_valid = 1'b1; op654 = OP_LOAD; funct3 = F3_W; addr = 32'h40; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset.mem_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_reset.mem_req", mem_req, 1'b0);
        chk("async_reset.lsu_stall", lsu_stall, 1'b0);
        chk("async_reset.lsu_done", lsu_done, 1'b0);
        chk("async_reset.lsu_rdata", lsu_rdata, 32'h0);
        lsu_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = 32'h0;
        @(posedge clk); #1;
        e = model(OP_LOAD, F3_W, 32'h0, 32'h0, 32'hCAFEF00D, 1, last_rd);
        exp_q.push_back(e.rdata);
        run_txn(OP_LOAD, F3_W, 32'h0, 32'h0, 32'hCAFEF00D, 1, 1'b0, o);
        compare("after_reset_lw", o, e);
        last_rd = e.rdata;

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 1) == 1) ? OP_STORE : OP_LOAD;
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom();
            rwd = $urandom();
            rrd = $urandom();
            rw  = $urandom_range(0, 5);
            e = model(rop, rf3, ra, rwd, rrd, rw, last_rd);
            exp_q.push_back(e.rdata);
            run_txn(rop, rf3, ra, rwd, rrd, rw, ($urandom_range(0, 3) == 0), o);
            compare($sformatf("rand%0d", i), o, e);
            last_rd = e.rdata;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
